// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI initiator and its shift register.
// Latency: none, declarations only.
// Backpressure: not applicable.
package spi_pkg;

  localparam int FRAME_W = 10;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } spi_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SHIFT_OUT,
    ST_TURN,
    ST_SHIFT_IN,
    ST_GAP
  } spi_mst_state_e;

  // Slave select is held low for every state that belongs to a frame.
  function automatic logic ss_active(input spi_mst_state_e s);
    return (s == ST_SELECT) || (s == ST_SHIFT_OUT) ||
           (s == ST_TURN)   || (s == ST_SHIFT_IN);
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Host request/response and SPI pin bundle for spi_master.
// Latency: none, wiring only.
// Backpressure: start is only honoured while ready is high; nothing is queued.
interface spi_master_if;
  import spi_pkg::*;

  logic              start;
  logic [1:0]        cmd;
  logic [DATA_W-1:0] payload;
  logic              ready;
  logic              busy;
  logic              SS_n;
  logic              MOSI;
  logic              MISO;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  modport master (
    input  start, cmd, payload, MISO,
    output ready, busy, SS_n, MOSI, rd_data, rd_valid
  );

  modport slave (
    output start, cmd, payload, MISO,
    input  ready, busy, SS_n, MOSI, rd_data, rd_valid
  );

endinterface

// File: rtl/spi_shift_reg.sv
// Parallel-load shift register: MSB-first serial out, serial in at the LSB.
// Latency: one clk per load or shift.
// Backpressure: none; load wins over shift when both are asserted.
module spi_shift_reg #(
  parameter int W    = 10,
  parameter int RX_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [W-1:0]    load_dat,
  input  logic            shift,
  input  logic            ser_in,
  output logic            ser_out,
  output logic [RX_W-1:0] rx_dat
);

  logic [W-1:0] q;

  // Load a new frame word, otherwise shift one bit towards the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_dat;
    end else if (shift) begin
      q <= {q[W-2:0], ser_in};
    end
  end

  assign ser_out = q[W-1];
  // Bits already shifted in; the caller appends the bit arriving this cycle.
  assign rx_dat  = q[RX_W-1:0];

endmodule

// File: rtl/spi_master.sv
// SPI initiator: 10-bit {cmd,payload} frames out on MOSI, 8-bit read-back on MISO.
// Latency: SS_n low 11 cycles per frame, 19+RD_TURN for read-data; rd_valid on the cycle SS_n rises.
// Backpressure: start accepted only while ready; requests while busy are dropped.
module spi_master
  import spi_pkg::*;
#(
  parameter int RD_TURN = 2,
  parameter int GAP     = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_master_if.master  bus
);

  spi_mst_state_e    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  spi_cmd_e          cmd_q;
  logic              ready;
  logic              accept;
  logic              shift_en;
  logic              ser_in;
  logic              sr_msb;
  logic [DATA_W-2:0] sr_rx;
  logic              rx_done;
  logic              ss_n_q;
  logic              mosi_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  // Last count value of each state; the counter reloads with it on entry.
  function automatic logic [CNT_W-1:0] state_last(input spi_mst_state_e s);
    case (s)
      ST_SHIFT_OUT: return CNT_W'(FRAME_W - 1);
      ST_TURN:      return CNT_W'(RD_TURN - 1);
      ST_SHIFT_IN:  return CNT_W'(DATA_W - 1);
      ST_GAP:       return CNT_W'(GAP - 1);
      default:      return '0;
    endcase
  endfunction

  // The last gap cycle already counts as ready so back-to-back frames
  // see exactly GAP high cycles of SS_n.
  assign ready   = (state_q == ST_IDLE) || ((state_q == ST_GAP) && (cnt_q == '0));
  assign accept  = bus.start && ready;
  assign rx_done = (state_q == ST_SHIFT_IN) && (cnt_q == '0);

  // Next-state and counter reload/decrement.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      ST_IDLE:      if (accept) state_d = ST_SELECT;
      ST_SELECT:    if (cnt_q == '0) state_d = ST_SHIFT_OUT;
      ST_SHIFT_OUT: if (cnt_q == '0) state_d = (cmd_q == CMD_RD_DATA) ? ST_TURN : ST_GAP;
      ST_TURN:      if (cnt_q == '0) state_d = ST_SHIFT_IN;
      ST_SHIFT_IN:  if (cnt_q == '0) state_d = ST_GAP;
      ST_GAP:       if (cnt_q == '0) state_d = accept ? ST_SELECT : ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
    if (state_d != state_q) begin
      cnt_d = state_last(state_d);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // State, counter and latched command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cmd_q   <= CMD_WR_ADDR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) cmd_q <= spi_cmd_e'(bus.cmd);
    end
  end

  // One shift per MOSI bit presented and per MISO bit sampled; MISO is
  // masked outside the read window so X/Z never enters the register.
  assign shift_en = (state_d == ST_SHIFT_OUT) || (state_q == ST_SHIFT_IN);
  assign ser_in   = (state_q == ST_SHIFT_IN) ? bus.MISO : 1'b0;

  spi_shift_reg #(
    .W    (FRAME_W),
    .RX_W (DATA_W - 1)
  ) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_dat ({bus.cmd, bus.payload}),
    .shift    (shift_en),
    .ser_in   (ser_in),
    .ser_out  (sr_msb),
    .rx_dat   (sr_rx)
  );

  // Registered pin outputs and read-back byte, driven from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      ss_n_q     <= !ss_active(state_d);
      mosi_q     <= (state_d == ST_SHIFT_OUT) ? sr_msb : 1'b0;
      rd_valid_q <= rx_done;
      if (rx_done) rd_data_q <= {sr_rx, bus.MISO};
    end
  end

  assign bus.ready    = ready;
  assign bus.busy     = !ready;
  assign bus.SS_n     = ss_n_q;
  assign bus.MOSI     = mosi_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with RD_TURN=2, GAP=1.
// Latency: samples 1 time unit after each rising clk edge.
// Backpressure: waits for ready (bounded) before each request.
module tb_spi_master;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  spi_master_if bus ();

  spi_master #(.RD_TURN(2), .GAP(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Per-cycle history; index k is the sample taken just after edge E_k.
  logic ss_h   [0:63];
  logic mosi_h [0:63];
  logic vld_h  [0:63];

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] pl;
    logic [7:0] mb;
    logic [9:0] bits;
    int         ss_low;
    int         vld_k;
    logic [7:0] rdd;
  } vec_t;

  vec_t tbl [5];
  logic [7:0] ram [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic accept(input logic [1:0] c, input logic [7:0] p);
    int w;
    w = 0;
    while (bus.ready !== 1'b1 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 50) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ready_wait: ready still %b after 50 cycles, expected 1", bus.ready);
    end
    bus.start   = 1'b1;
    bus.cmd     = c;
    bus.payload = p;
    @(posedge clk); #1;
  endtask

  task automatic capture(input int n, input logic [7:0] mb, input int miso_k,
                         input int drop_k, input int pulse_k);
    for (int k = 0; k < n; k++) begin
      ss_h[k]   = bus.SS_n;
      mosi_h[k] = bus.MOSI;
      vld_h[k]  = bus.rd_valid;
      if (k == drop_k) bus.start = 1'b0;
      if (pulse_k >= 0 && k == pulse_k) bus.start = 1'b1;
      if (pulse_k >= 0 && k == pulse_k + 1) bus.start = 1'b0;
      if (miso_k >= 0 && k >= miso_k && k < miso_k + 8) bus.MISO = mb[7 - (k - miso_k)];
      else bus.MISO = 1'bx;
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [9:0] bits_at(input int k0);
    logic [9:0] b;
    for (int j = 0; j < 10; j++) b[9 - j] = mosi_h[k0 + 1 + j];
    return b;
  endfunction

  function automatic int count_low(input int n);
    int c = 0;
    for (int k = 0; k < n; k++) if (ss_h[k] !== 1'b1) c++;
    return c;
  endfunction

  function automatic int count_vld(input int n);
    int c = 0;
    for (int k = 0; k < n; k++) if (vld_h[k] !== 1'b0) c++;
    return c;
  endfunction

  function automatic int first_vld(input int n);
    for (int k = 0; k < n; k++) if (vld_h[k] === 1'b1) return k;
    return -1;
  endfunction

  function automatic int mosi_extra(input int n);
    int c = 0;
    for (int k = 0; k < n; k++) if ((k < 1 || k > 10) && mosi_h[k] !== 1'b0) c++;
    return c;
  endfunction

  task automatic run_frame(input logic [1:0] c, input logic [7:0] p, input logic [7:0] mb);
    accept(c, p);
    capture(36, mb, 13, 0, -1);
  endtask

  initial begin
    int fe;
    int hi;
    logic [9:0] b;
    logic [7:0] wr_addr;
    logic [7:0] rd_addr;

    n_cmp  = 0;
    n_fail = 0;
    tbl[0] = '{2'b00, 8'h3C, 8'h00, 10'h03C, 11, -1, 8'h00};
    tbl[1] = '{2'b11, 8'h00, 8'hA5, 10'h300, 21, 21, 8'hA5};
    tbl[2] = '{2'b10, 8'h12, 8'h00, 10'h212, 11, -1, 8'hA5};
    tbl[3] = '{2'b11, 8'hFF, 8'h3C, 10'h3FF, 21, 21, 8'h3C};
    tbl[4] = '{2'b01, 8'h55, 8'h00, 10'h155, 11, -1, 8'h3C};

    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.cmd     = 2'b00;
    bus.payload = 8'h00;
    bus.MISO    = 1'bx;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ss_n",     bus.SS_n,     1);
    chk("rst_mosi",     bus.MOSI,     0);
    chk("rst_rd_data",  bus.rd_data,  0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_ready",    bus.ready,    1);
    chk("rst_busy",     bus.busy,     0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset dropped at E14 of a read-data frame.
    accept(2'b11, 8'h00);
    capture(14, 8'hFF, 13, 0, -1);
    chk("mid_pre_ss_n", ss_h[13], 0);
    rst_n = 1'b0;
    #1;
    chk("mid_ss_n",     bus.SS_n,     1);
    chk("mid_mosi",     bus.MOSI,     0);
    chk("mid_rd_valid", bus.rd_valid, 0);
    chk("mid_ready",    bus.ready,    1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    capture(20, 8'h00, -1, -1, -1);
    chk("mid_no_vld",   count_vld(20), 0);
    chk("mid_ss_idle",  count_low(20), 0);
    chk("mid_rd_data",  bus.rd_data,   0);
    chk("mid_ready_after", bus.ready,  1);

    // Table of single frames.
    for (int i = 0; i < 5; i++) begin
      run_frame(tbl[i].cmd, tbl[i].pl, tbl[i].mb);
      chk($sformatf("v%0d_bits", i),    bits_at(0),    tbl[i].bits);
      chk($sformatf("v%0d_ss_low", i),  count_low(36), tbl[i].ss_low);
      chk($sformatf("v%0d_vld_cnt", i), count_vld(36), (tbl[i].vld_k >= 0) ? 1 : 0);
      chk($sformatf("v%0d_vld_k", i),   first_vld(36), tbl[i].vld_k);
      chk($sformatf("v%0d_mosi_idle", i), mosi_extra(36), 0);
      chk($sformatf("v%0d_rd_data", i), bus.rd_data,   tbl[i].rdd);
    end

    // Back-to-back with start held: write data 0x55 then read address 0x12.
    accept(2'b01, 8'h55);
    bus.cmd     = 2'b10;
    bus.payload = 8'h12;
    capture(40, 8'h00, -1, 12, -1);
    chk("b2b_bits1", bits_at(0), 10'h155);
    fe = 0;
    while (fe < 39 && ss_h[fe] !== 1'b1) fe++;
    hi = 0;
    while (fe + hi < 39 && ss_h[fe + hi] === 1'b1) hi++;
    chk("b2b_first_end", fe, 11);
    chk("b2b_gap", hi, 1);
    chk("b2b_bits2", bits_at(fe + hi), 10'h212);
    chk("b2b_ss_low", count_low(40), 22);

    // start pulsed at E5 while busy, with cmd/payload also changed.
    accept(2'b01, 8'h81);
    bus.cmd     = 2'b11;
    bus.payload = 8'h00;
    capture(40, 8'h00, -1, 0, 4);
    chk("ign_bits",   bits_at(0),    10'h181);
    chk("ign_ss_low", count_low(40), 11);
    chk("ign_no_vld", count_vld(40), 0);

    // End-to-end through a small slave/RAM model.
    for (int a = 0; a < 256; a++) ram[a] = 8'h00;
    wr_addr = 8'h00;
    rd_addr = 8'h00;
    for (int f = 0; f < 4; f++) begin
      case (f)
        0: run_frame(2'b00, 8'h07, 8'h00);
        1: run_frame(2'b01, 8'hC3, 8'h00);
        2: run_frame(2'b10, 8'h07, 8'h00);
        default: run_frame(2'b11, 8'h00, ram[rd_addr]);
      endcase
      b = bits_at(0);
      case (b[9:8])
        2'b00: wr_addr = b[7:0];
        2'b01: ram[wr_addr] = b[7:0];
        2'b10: rd_addr = b[7:0];
        default: ;
      endcase
    end
    chk("e2e_rd_data", bus.rd_data, 8'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
